// File: rtl/dtack_wait_state_controller_if.sv
// 68k bus-side signals of the DTACK sequencer.
// master = CPU/decoder side, slave = sequencer side.
interface dtack_wait_state_controller_if #(
  parameter int NUM_DEV = 4
);
  logic               AS_L;
  logic [NUM_DEV-1:0] DevSelect_H;
  logic [NUM_DEV-1:0] DevDtack_L;
  logic               DtackOut_L;
  logic               BusError_L;
  logic               Busy_H;
  logic               CycleDone_H;

  modport master (
    output AS_L,
    output DevSelect_H,
    output DevDtack_L,
    input  DtackOut_L,
    input  BusError_L,
    input  Busy_H,
    input  CycleDone_H
  );

  modport slave (
    input  AS_L,
    input  DevSelect_H,
    input  DevDtack_L,
    output DtackOut_L,
    output BusError_L,
    output Busy_H,
    output CycleDone_H
  );
endinterface

// File: rtl/dtack_wait_state_controller.sv
// Clocked DTACK/BERR sequencer for slow and handshake 68k devices.
// Optional bus-error timeout: define DTACK_TIMEOUT_EN.
module dtack_wait_state_controller #(
  parameter int                         NUM_DEV     = 4,
  parameter int                         CNT_W       = 4,
  parameter logic [NUM_DEV*CNT_W-1:0]   WAIT_STATES = 16'h3210,
  parameter logic [NUM_DEV-1:0]         EXT_MASK    = 4'b0011
`ifdef DTACK_TIMEOUT_EN
  ,
  parameter int                         TIMEOUT_CYC = 255
`endif
) (
  input logic Clk,
  input logic Reset_H,
  dtack_wait_state_controller_if.slave bus
);

  localparam int CH_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  typedef enum logic [1:0] {
    IDLE, WAIT, ACK, BERR
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic [CH_W-1:0] pick;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ws_pick;
  logic            dtack_q, dtack_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            any_sel;
  logic            ack_hit;

`ifdef DTACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          berr_q, berr_d;
`endif

  // lowest-index select wins
  always_comb begin
    pick = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (bus.DevSelect_H[i]) pick = CH_W'(i);
    end
  end

  assign any_sel = |bus.DevSelect_H;
  assign ws_pick = WAIT_STATES[int'(pick)*CNT_W +: CNT_W];

  always_comb begin
    if (EXT_MASK[chan_q]) ack_hit = ~bus.DevDtack_L[chan_q];
    else                  ack_hit = (wcnt_q == CNT_W'(1));
  end

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state_q <= IDLE;
      chan_q  <= '0;
      wcnt_q  <= '0;
      dtack_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DTACK_TIMEOUT_EN
      tcnt_q  <= '0;
      berr_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      wcnt_q  <= wcnt_d;
      dtack_q <= dtack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DTACK_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      berr_q  <= berr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    wcnt_d  = wcnt_q;
`ifdef DTACK_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!bus.AS_L) begin
          if (!any_sel) begin
            state_d = ACK;
          end else begin
            chan_d = pick;
            wcnt_d = ws_pick;
            if (!EXT_MASK[pick] && ws_pick == '0)
              state_d = ACK;
            else
              state_d = WAIT;
          end
`ifdef DTACK_TIMEOUT_EN
          tcnt_d = '0;
`endif
        end
      end
      WAIT: begin
        if (wcnt_q != '0) wcnt_d = wcnt_q - CNT_W'(1);
`ifdef DTACK_TIMEOUT_EN
        if (tcnt_q != TW'(TIMEOUT_CYC))
          tcnt_d = tcnt_q + TW'(1);
`endif
        // abort beats acknowledge, acknowledge beats timeout
        if (bus.AS_L)
          state_d = IDLE;
        else if (ack_hit)
          state_d = ACK;
`ifdef DTACK_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYC - 1))
          state_d = BERR;
`endif
      end
      ACK: begin
        if (bus.AS_L) state_d = IDLE;
      end
      BERR: begin
        if (bus.AS_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dtack_d = ~(state_q == ACK && !bus.AS_L);
    done_d  = (state_q == ACK || state_q == BERR) && bus.AS_L;
    busy_d  = (state_d != IDLE);
`ifdef DTACK_TIMEOUT_EN
    berr_d  = ~(state_q == BERR && !bus.AS_L);
`endif
  end

  assign bus.DtackOut_L  = dtack_q;
  assign bus.Busy_H      = busy_q;
  assign bus.CycleDone_H = done_q;
`ifdef DTACK_TIMEOUT_EN
  assign bus.BusError_L  = berr_q;
`else
  assign bus.BusError_L  = 1'b1;
`endif

endmodule

// File: tb/tb_dtack_wait_state_controller.sv
// Bench for dtack_wait_state_controller: directed and random bus cycles
// checked against a cycle-level model derived from the acknowledge rules.
module tb_dtack_wait_state_controller;

  localparam logic [15:0] WS   = 16'h3210;
  localparam logic [3:0]  EXTM = 4'b0011;
  localparam int          NEVER = 1 << 30;
`ifdef DTACK_TIMEOUT_EN
  localparam int          TMO = 255;
`endif

  logic Clk;
  logic Reset_H;
  int   errors = 0;
  int   checks = 0;

  dtack_wait_state_controller_if #(.NUM_DEV(4)) bus ();

  dtack_wait_state_controller dut (
    .Clk     (Clk),
    .Reset_H (Reset_H),
    .bus     (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // AS_L is sampled low at edges 0..h and high at edge h+1.
  // d = edge at which the device DTACK is first sampled low (ext channels).
  task automatic run_cycle(input string tag, input logic [3:0] sel,
                           input int d, input int h);
    int chan;
    bit ext;
    int e;
    int b;
    logic [3:0] r;
    chan = -1;
    for (int i = 3; i >= 0; i--) if (sel[i]) chan = i;
    ext = 1'b0;
    e = 0;
    b = NEVER;
    if (chan >= 0) begin
      ext = EXTM[chan];
      if (ext) e = d;
      else e = int'((WS >> (4 * chan)) & 16'hF);
    end
`ifdef DTACK_TIMEOUT_EN
    if (ext && d > TMO) begin
      e = NEVER;
      b = TMO;
    end
`endif
    bus.AS_L = 1'b0;
    bus.DevSelect_H = sel;
    for (int k = 0; k <= h + 1; k++) begin
      if (k == h + 1) bus.AS_L = 1'b1;
      if (k > 0) bus.DevSelect_H = 4'($urandom);
      r = 4'($urandom);
      if (ext) r[chan] = (k >= d) ? 1'b0 : 1'b1;
      bus.DevDtack_L = r;
      @(posedge Clk);
      #1;
      chk($sformatf("%s.dtack@%0d", tag, k), bus.DtackOut_L,
          !(k >= e + 1 && k <= h));
      chk($sformatf("%s.berr@%0d", tag, k), bus.BusError_L,
          !(k >= b + 1 && k <= h));
      chk($sformatf("%s.done@%0d", tag, k), bus.CycleDone_H,
          (k == h + 1) && (e <= h || b <= h));
      chk($sformatf("%s.busy@%0d", tag, k), bus.Busy_H, k <= h);
    end
    @(posedge Clk);
    #1;
    chk({tag, ".idle_dtack"}, bus.DtackOut_L, 1'b1);
    chk({tag, ".idle_busy"}, bus.Busy_H, 1'b0);
    chk({tag, ".idle_done"}, bus.CycleDone_H, 1'b0);
  endtask

  initial begin
    logic [3:0] s;
    int dd;
    int hh;
    Reset_H = 1'b1;
    bus.AS_L = 1'b1;
    bus.DevSelect_H = 4'b0000;
    bus.DevDtack_L = 4'b1111;
    #3;
    chk("reset.dtack", bus.DtackOut_L, 1'b1);
    chk("reset.berr", bus.BusError_L, 1'b1);
    chk("reset.busy", bus.Busy_H, 1'b0);
    chk("reset.done", bus.CycleDone_H, 1'b0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_H = 1'b0;
    @(posedge Clk);
    #1;

    run_cycle("nosel", 4'b0000, 1, 2);
    run_cycle("ws3", 4'b1000, 1, 5);
    run_cycle("ext0", 4'b0001, 6, 8);
    run_cycle("prio", 4'b1100, 1, 4);
    run_cycle("abort", 4'b1100, 1, 1);
    run_cycle("ext1", 4'b0010, 3, 6);
    run_cycle("ext_late", 4'b0001, 5, 5);
    run_cycle("ws2_edge", 4'b0100, 1, 2);

    // reset pulsed while DTACK is asserted
    bus.AS_L = 1'b0;
    bus.DevSelect_H = 4'b0000;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("rst_mid.pre_dtack", bus.DtackOut_L, 1'b0);
    #2;
    Reset_H = 1'b1;
    #1;
    chk("rst_mid.dtack", bus.DtackOut_L, 1'b1);
    chk("rst_mid.busy", bus.Busy_H, 1'b0);
    chk("rst_mid.done", bus.CycleDone_H, 1'b0);
    bus.AS_L = 1'b1;
    @(posedge Clk);
    #1;
    Reset_H = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_mid.after_dtack", bus.DtackOut_L, 1'b1);
    run_cycle("post_rst", 4'b0100, 1, 3);

    for (int n = 0; n < 40; n++) begin
      s  = 4'($urandom_range(0, 15));
      dd = $urandom_range(1, 9);
      hh = $urandom_range(0, 9);
      run_cycle($sformatf("rnd%0d", n), s, dd, hh);
    end

    run_cycle("hang", 4'b0001, NEVER, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
